// File: rtl/serial_subtractor_pkg.sv
// Shared encodings and saturation limits for the bit-serial subtractor.
package serial_subtractor_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Limits are built 64 bits wide; callers truncate to their own WIDTH (<= 64).
  function automatic logic [63:0] sat_pos(int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_neg(int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/serial_subtractor_half_sub.sv
// One half-subtractor cell; two of them plus an OR form a full-subtract bit.
module half_subtractor (
  input  logic A,
  input  logic B,
  output logic Diff,
  output logic Bout
);

  assign Diff = A ^ B;
  assign Bout = ~A & B;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, LSB first, one bit per clock,
// with signed overflow detection and optional saturation.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter bit SATURATE = 1'b0
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             Ovf
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] SAT_POS = WIDTH'(sat_pos(WIDTH));
  localparam logic [WIDTH-1:0] SAT_NEG = WIDTH'(sat_neg(WIDTH));

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] ra_q, ra_d, rb_q, rb_d, r_q, r_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             borrow_q, borrow_d;
  logic             sa_q, sa_d, sb_q, sb_d;
  logic             bout_q, bout_d, ovf_q, ovf_d;

  logic hs0_diff, hs0_bout, bit_d, hs1_bout, borrow_nx, accept;

  half_subtractor u_hs0 (.A(ra_q[0]),  .B(rb_q[0]),  .Diff(hs0_diff), .Bout(hs0_bout));
  half_subtractor u_hs1 (.A(hs0_diff), .B(borrow_q), .Diff(bit_d),    .Bout(hs1_bout));

  assign borrow_nx = hs0_bout | hs1_bout;
  assign accept    = Start && (state_q == ST_IDLE || state_q == ST_DONE);

  always_comb begin
    state_d  = state_q;
    ra_d     = ra_q;
    rb_d     = rb_q;
    r_d      = r_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;
    case (state_q)
      ST_SHIFT: begin
        ra_d     = ra_q >> 1;
        rb_d     = rb_q >> 1;
        r_d      = {bit_d, r_q[WIDTH-1:1]};
        borrow_d = borrow_nx;
        cnt_d    = cnt_q + CW'(1);
        // Last bit: publish result together with the transition into DONE.
        if (cnt_q == LAST) begin
          state_d = ST_DONE;
          bout_d  = borrow_nx;
          ovf_d   = (sa_q != sb_q) && (r_d[WIDTH-1] != sa_q);
          diff_d  = (SATURATE && ovf_d) ? (sa_q ? SAT_NEG : SAT_POS) : r_d;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_IDLE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (accept) begin
      state_d  = ST_SHIFT;
      ra_d     = A;
      rb_d     = B;
      borrow_d = 1'b0;
      cnt_d    = '0;
      sa_d     = A[WIDTH-1];
      sb_d     = B[WIDTH-1];
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= ST_IDLE;
      ra_q     <= '0;
      rb_q     <= '0;
      r_q      <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ra_q     <= ra_d;
      rb_q     <= rb_d;
      r_q      <= r_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign Busy = (state_q == ST_SHIFT);
  assign Done = (state_q == ST_DONE);
  assign Diff = diff_q;
  assign Bout = bout_q;
  assign Ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench: wrap and saturate instances share stimulus; results come from integer arithmetic.
module tb_serial_subtractor;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        Start;
  logic [15:0] A, B;
  logic        busy0, done0, bout0, ovf0;
  logic        busy1, done1, bout1, ovf1;
  logic [15:0] diff0, diff1;

  int errs   = 0;
  int checks = 0;
  logic [15:0] hold_d0, hold_d1;

  always #5 Clk = ~Clk;

  serial_subtractor #(.WIDTH(16), .SATURATE(1'b0)) u_wrap (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .A(A), .B(B),
    .Busy(busy0), .Done(done0), .Diff(diff0), .Bout(bout0), .Ovf(ovf0));

  serial_subtractor #(.WIDTH(16), .SATURATE(1'b1)) u_sat (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .A(A), .B(B),
    .Busy(busy1), .Done(done1), .Diff(diff1), .Bout(bout1), .Ovf(ovf1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: signed integer difference decides overflow and clamp direction.
  function automatic void model(input logic [15:0] a, input logic [15:0] b, input bit sat,
                                output logic [15:0] d, output logic bo, output logic ov);
    int sd;
    sd = int'($signed(a)) - int'($signed(b));
    bo = (a < b);
    ov = (sd > 32767) || (sd < -32768);
    d  = a - b;
    if (sat && ov) d = (sd > 0) ? 16'h7FFF : 16'h8000;
  endfunction

  // Called at a negedge; drives Start for the next edge, returns one negedge later.
  task automatic issue(input logic [15:0] a, input logic [15:0] b);
    A = a; B = b; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0; A = 16'($urandom); B = 16'($urandom);
  endtask

  // Waits for Done (returns at that negedge) and checks latency, Busy span and results.
  task automatic wait_done(input logic [15:0] a, input logic [15:0] b, input bit repulse);
    int n, busy_cnt;
    logic [15:0] e0, e1;
    logic eb0, eo0, eb1, eo1;
    model(a, b, 1'b0, e0, eb0, eo0);
    model(a, b, 1'b1, e1, eb1, eo1);
    n = 0; busy_cnt = 0;
    while (!done0 && n < 40) begin
      if (busy0) busy_cnt++;
      if (n == 8) begin
        chk("hold_diff_wrap", diff0, hold_d0);
        chk("hold_diff_sat", diff1, hold_d1);
      end
      if (repulse && n == 5) begin
        Start = 1'b1; A = 16'($urandom); B = 16'($urandom);
      end else Start = 1'b0;
      @(negedge Clk);
      n++;
    end
    chk("latency", n, 16);
    chk("busy_cycles", busy_cnt, 16);
    chk("done_sat", done1, 1'b1);
    chk("diff_wrap", diff0, e0);
    chk("bout_wrap", bout0, eb0);
    chk("ovf_wrap", ovf0, eo0);
    chk("diff_sat", diff1, e1);
    chk("bout_sat", bout1, eb1);
    chk("ovf_sat", ovf1, eo1);
    hold_d0 = e0; hold_d1 = e1;
  endtask

  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input bit repulse);
    issue(a, b);
    wait_done(a, b, repulse);
    @(negedge Clk);
    chk("done_pulse", done0, 1'b0);
  endtask

  initial begin
    int saw_done;
    Rst_n = 1'b0; Start = 1'b0; A = '0; B = '0;
    hold_d0 = '0; hold_d1 = '0;
    repeat (3) @(negedge Clk);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_done", done0, 1'b0);
    chk("rst_diff", diff0, 16'h0);
    chk("rst_flags", {bout0, ovf0}, 2'b00);
    Rst_n = 1'b1;
    @(negedge Clk);

    do_op(16'h0005, 16'h0003, 1'b0);
    do_op(16'h0003, 16'h0005, 1'b0);
    do_op(16'h7FFF, 16'hFFFF, 1'b0);
    do_op(16'h8000, 16'h0001, 1'b0);
    do_op(16'h8000, 16'h8000, 1'b0);
    do_op(16'h1234, 16'h5678, 1'b1);

    // Back-to-back: second Start lands in the DONE cycle of the first.
    issue(16'h4000, 16'hC000);
    wait_done(16'h4000, 16'hC000, 1'b0);
    issue(16'hC000, 16'h4001);
    wait_done(16'hC000, 16'h4001, 1'b0);
    @(negedge Clk);

    // Abort mid-operation.
    issue(16'h7000, 16'h9000);
    repeat (7) @(negedge Clk);
    Rst_n = 1'b0;
    #1;
    chk("abort_diff", diff0, 16'h0);
    chk("abort_busy", busy0, 1'b0);
    chk("abort_flags", {bout0, ovf0, done0}, 3'b000);
    @(negedge Clk);
    Rst_n = 1'b1;
    saw_done = 0;
    repeat (20) begin
      @(negedge Clk);
      if (done0 || done1) saw_done++;
    end
    chk("abort_no_done", saw_done, 0);
    hold_d0 = '0; hold_d1 = '0;
    do_op(16'hFFFF, 16'h0001, 1'b0);

    for (int i = 0; i < 20; i++) begin
      logic [15:0] ra, rb;
      ra = 16'($urandom); rb = 16'($urandom);
      if (i % 4 == 0) rb = {~ra[15], 15'($urandom)};
      do_op(ra, rb, (i % 3) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
